// File: rtl/ad7606_emulator.sv
// AD7606 responder for loopback self-test: answers CONVST with an OS-scaled BUSY
// pulse and serves {channel, frame} pattern words on CS_n/RD_n strobes.
`timescale 1ns/1ps
module ad7606_emulator #(
    parameter int unsigned NUM_CH    = 8,
    parameter int unsigned BUSY_BASE = 200
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        adc_reset,
    input  logic        adc_convst_a,
    input  logic        adc_convst_b,
    input  logic [2:0]  adc_os,
    input  logic        adc_range,
    input  logic        adc_cs_n,
    input  logic        adc_rd_n,
    output logic        adc_busy,
    output logic [15:0] adc_data,
    output logic        adc_frstdata
);

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned CH_W    = $clog2(NUM_CH);
    localparam int unsigned FRAME_W = DATA_W - CH_W;
    localparam int unsigned CNT_W   = 16;

    typedef enum logic {
        S_IDLE,
        S_CONV
    } state_t;

    state_t               r_state;
    logic                 r_convst_a_q;
    logic                 r_convst_b_q;
    logic                 r_rd_n_q;
    logic [CNT_W-1:0]     r_busy_cnt;
    logic [FRAME_W-1:0]   r_frame;
    logic [CH_W-1:0]      r_ch_idx;
    logic                 r_busy;
    logic [DATA_W-1:0]    r_data;
    logic                 r_frstdata;

    logic                 w_conv_rise;
    logic                 w_rd_fall;
    logic                 w_rd_rise;
    logic                 w_eoc;
    logic [2:0]           w_os_eff;
    logic [CNT_W-1:0]     w_busy_load;
    logic [CH_W-1:0]      w_ch_next;
    logic                 w_unused_range;

    // Range select only changes the analog front end of a real part.
    assign w_unused_range = adc_range;

    assign w_conv_rise = (adc_convst_a & adc_convst_b) & ~(r_convst_a_q & r_convst_b_q);
    assign w_rd_fall   = ~adc_rd_n &  r_rd_n_q & ~adc_cs_n;
    assign w_rd_rise   =  adc_rd_n & ~r_rd_n_q & ~adc_cs_n;
    assign w_eoc       = (r_state == S_CONV) && (r_busy_cnt == '0);
    assign w_os_eff    = (adc_os == 3'd7) ? 3'd0 : adc_os;
    assign w_busy_load = (CNT_W'(BUSY_BASE) << w_os_eff) - CNT_W'(1);
    assign w_ch_next   = (r_ch_idx == CH_W'(NUM_CH - 1)) ? '0 : r_ch_idx + CH_W'(1);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_convst_a_q <= 1'b0;
            r_convst_b_q <= 1'b0;
            r_rd_n_q     <= 1'b0;
            r_busy_cnt   <= '0;
            r_frame      <= '0;
            r_ch_idx     <= '0;
            r_busy       <= 1'b0;
            r_data       <= '0;
            r_frstdata   <= 1'b0;
        end else begin
            r_convst_a_q <= adc_convst_a;
            r_convst_b_q <= adc_convst_b;
            r_rd_n_q     <= adc_rd_n;
            if (adc_reset) begin
                r_state    <= S_IDLE;
                r_busy_cnt <= '0;
                r_frame    <= '0;
                r_ch_idx   <= '0;
                r_busy     <= 1'b0;
                r_data     <= '0;
                r_frstdata <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_conv_rise) begin
                            r_state    <= S_CONV;
                            r_busy     <= 1'b1;
                            r_busy_cnt <= w_busy_load;
                        end
                    end
                    S_CONV: begin
                        if (r_busy_cnt == '0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_frame <= r_frame + FRAME_W'(1);
                        end else begin
                            r_busy_cnt <= r_busy_cnt - CNT_W'(1);
                        end
                    end
                endcase

                // End of conversion restarts the frame even over a concurrent read.
                if (w_eoc) begin
                    r_ch_idx <= '0;
                end else if (w_rd_rise) begin
                    r_ch_idx <= w_ch_next;
                end

                if (adc_cs_n) begin
                    r_data     <= '0;
                    r_frstdata <= 1'b0;
                end else if (w_rd_fall) begin
                    r_data     <= {r_ch_idx, r_frame};
                    r_frstdata <= (r_ch_idx == '0);
                end
            end
        end
    end

    assign adc_busy     = r_busy;
    assign adc_data     = r_data;
    assign adc_frstdata = r_frstdata;

endmodule

// File: tb/tb_ad7606_emulator.sv
// Directed bench for ad7606_emulator: BUSY timing, read pattern, resets, bus idle.
`timescale 1ns/1ps
module tb_ad7606_emulator;

    logic        sys_clk      = 1'b0;
    logic        rst_n        = 1'b0;
    logic        adc_reset    = 1'b0;
    logic        adc_convst_a = 1'b0;
    logic        adc_convst_b = 1'b0;
    logic [2:0]  adc_os       = 3'd0;
    logic        adc_range    = 1'b0;
    logic        adc_cs_n     = 1'b1;
    logic        adc_rd_n     = 1'b1;
    logic        adc_busy;
    logic [15:0] adc_data;
    logic        adc_frstdata;

    int n_checks = 0;
    int n_pass   = 0;

    ad7606_emulator dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .adc_reset    (adc_reset),
        .adc_convst_a (adc_convst_a),
        .adc_convst_b (adc_convst_b),
        .adc_os       (adc_os),
        .adc_range    (adc_range),
        .adc_cs_n     (adc_cs_n),
        .adc_rd_n     (adc_rd_n),
        .adc_busy     (adc_busy),
        .adc_data     (adc_data),
        .adc_frstdata (adc_frstdata)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic step_n(input int n);
        repeat (n) step();
    endtask

    task automatic start_conv(input logic [2:0] os);
        adc_os       = os;
        adc_convst_a = 1'b1;
        adc_convst_b = 1'b1;
        step();
        adc_convst_a = 1'b0;
        adc_convst_b = 1'b0;
    endtask

    task automatic measure_busy(output int w);
        w = 0;
        while (adc_busy === 1'b1 && w < 20000) begin
            w++;
            step();
        end
    endtask

    task automatic read_word(output logic [15:0] d, output logic f);
        adc_cs_n = 1'b0;
        adc_rd_n = 1'b0;
        step();
        d = adc_data;
        f = adc_frstdata;
        adc_rd_n = 1'b1;
        step();
        adc_cs_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (adc_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", adc_busy); else n_pass++;
        n_checks++; if (adc_data !== 16'h0000) $display("FAIL reset_data: got %h want 0000", adc_data); else n_pass++;
        n_checks++; if (adc_frstdata !== 1'b0) $display("FAIL reset_frst: got %b want 0", adc_frstdata); else n_pass++;
        step_n(3);
        rst_n = 1'b1;
        step_n(2);
    endtask

    task automatic test_conv_os0();
        int w;
        start_conv(3'd0);
        n_checks++; if (adc_busy !== 1'b1) $display("FAIL os0_busy_rise: got %b want 1", adc_busy); else n_pass++;
        measure_busy(w);
        n_checks++; if (w != 200) $display("FAIL os0_width: got %0d want 200", w); else n_pass++;
    endtask

    task automatic test_read_frame();
        logic [15:0] d;
        logic        f;
        logic [15:0] exp_d;
        for (int ch = 0; ch < 8; ch++) begin
            read_word(d, f);
            exp_d = {3'(ch), 13'd1};
            n_checks++; if (d !== exp_d) $display("FAIL read_ch%0d_data: got %h want %h", ch, d, exp_d); else n_pass++;
            n_checks++; if (f !== (ch == 0)) $display("FAIL read_ch%0d_frst: got %b want %b", ch, f, (ch == 0)); else n_pass++;
        end
        n_checks++; if (adc_data !== 16'h0000) $display("FAIL idle_after_read: got %h want 0000", adc_data); else n_pass++;
        read_word(d, f);
        n_checks++; if (d !== 16'h0001) $display("FAIL ninth_read_data: got %h want 0001", d); else n_pass++;
        n_checks++; if (f !== 1'b1) $display("FAIL ninth_read_frst: got %b want 1", f); else n_pass++;
    endtask

    task automatic test_os_widths();
        int w;
        logic [15:0] d;
        logic        f;
        start_conv(3'd3);
        measure_busy(w);
        n_checks++; if (w != 1600) $display("FAIL os3_width: got %0d want 1600", w); else n_pass++;
        start_conv(3'd7);
        measure_busy(w);
        n_checks++; if (w != 200) $display("FAIL os7_width: got %0d want 200", w); else n_pass++;
        read_word(d, f);
        n_checks++; if (d !== 16'h0003) $display("FAIL os_frame3_data: got %h want 0003", d); else n_pass++;
        n_checks++; if (f !== 1'b1) $display("FAIL os_frame3_frst: got %b want 1", f); else n_pass++;
    endtask

    task automatic test_ignored_convst();
        int w;
        logic [15:0] d;
        logic        f;
        start_conv(3'd0);
        step_n(49);
        adc_convst_a = 1'b1;
        adc_convst_b = 1'b1;
        step();
        adc_convst_a = 1'b0;
        adc_convst_b = 1'b0;
        measure_busy(w);
        n_checks++; if (w != 150) $display("FAIL ignored_convst_remaining: got %0d want 150", w); else n_pass++;
        read_word(d, f);
        n_checks++; if (d !== 16'h0004) $display("FAIL ignored_convst_frame: got %h want 0004", d); else n_pass++;
    endtask

    task automatic test_read_during_conv();
        int w;
        logic [15:0] d;
        logic        f;
        start_conv(3'd1);
        step_n(10);
        read_word(d, f);
        n_checks++; if (d !== 16'h2004) $display("FAIL conv_read_data: got %h want 2004", d); else n_pass++;
        n_checks++; if (f !== 1'b0) $display("FAIL conv_read_frst: got %b want 0", f); else n_pass++;
        measure_busy(w);
        n_checks++; if (w != 387) $display("FAIL os1_remaining: got %0d want 387", w); else n_pass++;
        read_word(d, f);
        n_checks++; if (d !== 16'h0005) $display("FAIL post_conv_data: got %h want 0005", d); else n_pass++;
        n_checks++; if (f !== 1'b1) $display("FAIL post_conv_frst: got %b want 1", f); else n_pass++;
    endtask

    task automatic test_eoc_race();
        start_conv(3'd0);
        step_n(197);
        adc_cs_n = 1'b0;
        adc_rd_n = 1'b0;
        step_n(2);
        n_checks++; if (adc_data !== 16'h2005) $display("FAIL race_old_data: got %h want 2005", adc_data); else n_pass++;
        n_checks++; if (adc_busy !== 1'b1) $display("FAIL race_busy_last: got %b want 1", adc_busy); else n_pass++;
        adc_rd_n = 1'b1;
        step();
        n_checks++; if (adc_busy !== 1'b0) $display("FAIL race_busy_fall: got %b want 0", adc_busy); else n_pass++;
        adc_rd_n = 1'b0;
        step();
        n_checks++; if (adc_data !== 16'h0006) $display("FAIL race_new_data: got %h want 0006", adc_data); else n_pass++;
        n_checks++; if (adc_frstdata !== 1'b1) $display("FAIL race_new_frst: got %b want 1", adc_frstdata); else n_pass++;
        adc_rd_n = 1'b1;
        step();
        adc_cs_n = 1'b1;
        step();
    endtask

    task automatic test_device_reset();
        int w;
        logic [15:0] d;
        logic        f;
        start_conv(3'd0);
        step_n(99);
        adc_reset = 1'b1;
        step();
        n_checks++; if (adc_busy !== 1'b0) $display("FAIL devrst_busy: got %b want 0", adc_busy); else n_pass++;
        adc_convst_a = 1'b1;
        adc_convst_b = 1'b1;
        step_n(3);
        n_checks++; if (adc_busy !== 1'b0) $display("FAIL devrst_convst_ignored: got %b want 0", adc_busy); else n_pass++;
        adc_reset = 1'b0;
        step();
        n_checks++; if (adc_busy !== 1'b0) $display("FAIL devrst_release_busy: got %b want 0", adc_busy); else n_pass++;
        adc_convst_a = 1'b0;
        adc_convst_b = 1'b0;
        step();
        start_conv(3'd0);
        measure_busy(w);
        n_checks++; if (w != 200) $display("FAIL devrst_next_width: got %0d want 200", w); else n_pass++;
        read_word(d, f);
        n_checks++; if (d !== 16'h0001) $display("FAIL devrst_frame_data: got %h want 0001", d); else n_pass++;
        n_checks++; if (f !== 1'b1) $display("FAIL devrst_frame_frst: got %b want 1", f); else n_pass++;
    endtask

    task automatic test_cs_idle();
        logic [15:0] d;
        logic        f;
        adc_cs_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            adc_rd_n = 1'b0;
            step();
            n_checks++; if (adc_data !== 16'h0000) $display("FAIL cs_idle_data%0d: got %h want 0000", i, adc_data); else n_pass++;
            n_checks++; if (adc_frstdata !== 1'b0) $display("FAIL cs_idle_frst%0d: got %b want 0", i, adc_frstdata); else n_pass++;
            adc_rd_n = 1'b1;
            step();
        end
        read_word(d, f);
        n_checks++; if (d !== 16'h2001) $display("FAIL cs_idle_ch_hold: got %h want 2001", d); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int w;
        logic [15:0] d;
        logic        f;
        start_conv(3'd0);
        measure_busy(w);
        n_checks++; if (w != 200) $display("FAIL b2b_first_width: got %0d want 200", w); else n_pass++;
        start_conv(3'd2);
        n_checks++; if (adc_busy !== 1'b1) $display("FAIL b2b_accept: got %b want 1", adc_busy); else n_pass++;
        measure_busy(w);
        n_checks++; if (w != 800) $display("FAIL b2b_os2_width: got %0d want 800", w); else n_pass++;
        read_word(d, f);
        n_checks++; if (d !== 16'h0003) $display("FAIL b2b_frame_data: got %h want 0003", d); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_conv_os0();
        test_read_frame();
        test_os_widths();
        test_ignored_convst();
        test_read_during_conv();
        test_eoc_race();
        test_device_reset();
        test_cs_idle();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
